// File: rtl/wave_oscillator_if.sv
// Oscillator control/sample bundle: enable, divider word and waveform select in; sample stream and PWM pin out.
// Latency: none, wires only.
// Backpressure: none; the sample stream is free-running and the consumer must take every strobe.
interface wave_oscillator_if;
  logic        en;
  logic [15:0] divider;
  logic [1:0]  wave_sel;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        pwm_out;

  // Driver of the control word; sees the sample stream.
  modport master (
    output en, divider, wave_sel,
    input  sample, sample_valid, pwm_out
  );

  // The oscillator itself.
  modport slave (
    input  en, divider, wave_sel,
    output sample, sample_valid, pwm_out
  );
endinterface

// File: rtl/wave_oscillator.sv
// Wave oscillator: divider-paced phase accumulator producing square/saw/triangle samples; PWM pin when OSC_PWM_EN is defined.
// Latency: sample follows phase by one hz12M cycle; sample_valid marks the first cycle of each new phase value.
// Backpressure: none; samples stream continuously and the consumer must accept every sample_valid strobe.
module wave_oscillator #(
  parameter int         PHASE_BITS   = 8,
  parameter logic [7:0] SILENT_LEVEL = 8'h80
) (
  input  logic             hz12M,
  input  logic             reset,
  wave_oscillator_if.slave osc
);

  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           div_active_q, div_active_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;
  logic                  step_q, step_d;
  logic [7:0]            sample_q, sample_d;
  logic                  sample_valid_q, sample_valid_d;

  logic silent;
  logic at_step;
  logic at_wrap;

  // Map the top 8 phase bits to a sample value for the selected waveform.
  function automatic logic [7:0] wave_fn(input logic [7:0] p, input logic [1:0] sel);
    logic [7:0] res;
    case (sel)
      2'b00:   res = p[7] ? 8'hFF : 8'h00;
      2'b01:   res = p;
      2'b10:   res = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
      default: res = SILENT_LEVEL;
    endcase
    return res;
  endfunction

  assign silent  = ~osc.en | (osc.divider == 16'd0);
  assign at_step = (div_active_q != 16'd0) && (cnt_q == div_active_q - 16'd1);
  // The divider word is only re-sampled when the period ends, keeping pitch changes glitch-free.
  assign at_wrap = at_step && (&phase_q);

  // Next-state: silence clears everything, idle loads the divider, run counts and steps the phase.
  always_comb begin
    cnt_d          = cnt_q;
    div_active_d   = div_active_q;
    phase_d        = phase_q;
    step_d         = 1'b0;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    if (silent) begin
      cnt_d        = 16'd0;
      div_active_d = 16'd0;
      phase_d      = '0;
      sample_d     = SILENT_LEVEL;
    end else begin
      sample_d       = wave_fn(phase_q[PHASE_BITS-1 -: 8], osc.wave_sel);
      sample_valid_d = step_q;
      if (div_active_q == 16'd0) begin
        div_active_d = osc.divider;
        cnt_d        = 16'd0;
      end else if (at_step) begin
        cnt_d   = 16'd0;
        phase_d = phase_q + PHASE_BITS'(1);
        step_d  = 1'b1;
        if (at_wrap) begin
          div_active_d = osc.divider;
        end
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // Oscillator state registers with synchronous reset.
  always_ff @(posedge hz12M) begin
    if (reset) begin
      cnt_q          <= 16'd0;
      div_active_q   <= 16'd0;
      phase_q        <= '0;
      step_q         <= 1'b0;
      sample_q       <= SILENT_LEVEL;
      sample_valid_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      div_active_q   <= div_active_d;
      phase_q        <= phase_d;
      step_q         <= step_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign osc.sample       = sample_q;
  assign osc.sample_valid = sample_valid_q;

`ifdef OSC_PWM_EN
  logic [7:0] pwm_cnt_q, pwm_cnt_d;
  logic       pwm_out_q, pwm_out_d;

  // Free-running 8-bit carrier compared against the current sample.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    pwm_out_d = (pwm_cnt_q < sample_q);
  end

  // PWM counter and pin registers; the carrier keeps running through silence.
  always_ff @(posedge hz12M) begin
    if (reset) begin
      pwm_cnt_q <= 8'd0;
      pwm_out_q <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign osc.pwm_out = pwm_out_q;
`else
  assign osc.pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_wave_oscillator.sv
// Bench for wave_oscillator: directed scenarios plus randomized control changes against a behavioural model.
// Latency: model predicts outputs one edge at a time, sampled 1 time unit after each rising edge.
// Backpressure: not applicable; every cycle's outputs are compared.
module tb_wave_oscillator;
  localparam int NSTEPS = 256;

  logic hz12M = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  wave_oscillator_if osc_if();

  wave_oscillator dut (
    .hz12M (hz12M),
    .reset (reset),
    .osc   (osc_if)
  );

  always #5 hz12M = ~hz12M;

  // Behavioural model: per = active divider (0 = idle), ticks = cycles into the current period.
  int         m_per, m_ticks, m_phase, m_pwm_cnt;
  bit         m_step;
  logic [7:0] m_sample;
  logic       m_valid, m_pwm;

  function automatic logic [7:0] shape(input int p, input logic [1:0] sel);
    case (sel)
      2'b00:   return (p >= 128) ? 8'hFF : 8'h00;
      2'b01:   return 8'(p);
      2'b10:   return (p < 128) ? 8'(2 * p) : 8'(255 - 2 * (p - 128));
      default: return 8'h80;
    endcase
  endfunction

  // Advance one clock: update the model from the inputs seen at the edge, then settle.
  task automatic tick();
    @(posedge hz12M);
    if (reset) begin
      m_per = 0; m_ticks = 0; m_phase = 0; m_step = 0;
      m_sample = 8'h80; m_valid = 1'b0; m_pwm_cnt = 0; m_pwm = 1'b0;
    end else begin
`ifdef OSC_PWM_EN
      m_pwm = (m_pwm_cnt < int'(m_sample));
      m_pwm_cnt = (m_pwm_cnt + 1) % 256;
`else
      m_pwm = 1'b0;
`endif
      if (!osc_if.en || osc_if.divider == 16'd0) begin
        m_per = 0; m_ticks = 0; m_phase = 0; m_step = 0;
        m_sample = 8'h80; m_valid = 1'b0;
      end else begin
        m_sample = shape(m_phase, osc_if.wave_sel);
        m_valid  = m_step;
        m_step   = 0;
        if (m_per == 0) begin
          m_per = int'(osc_if.divider);
          m_ticks = 0;
        end else begin
          m_ticks++;
          if (m_ticks == m_per * NSTEPS) begin
            m_ticks = 0;
            m_per = int'(osc_if.divider);
            m_step = 1;
          end else begin
            m_step = (m_ticks % m_per == 0);
          end
          m_phase = m_ticks / m_per;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; osc_if.en = 1'b1; osc_if.divider = 16'd4; osc_if.wave_sel = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (osc_if.sample !== 8'h80 || osc_if.sample_valid !== 1'b0 || osc_if.pwm_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_state cyc%0d: got sample=%h valid=%b pwm=%b, want 80 0 0",
                 i, osc_if.sample, osc_if.sample_valid, osc_if.pwm_out);
      end
    end
  endtask

  task automatic test_sawtooth();
    int first01 = -1, second01 = -1, last = -1;
    logic [7:0] prev = 8'h00;
    reset = 1'b0;
    for (int i = 0; i < 1040; i++) begin
      tick();
      checks++;
      if (osc_if.sample !== m_sample || osc_if.sample_valid !== m_valid || osc_if.pwm_out !== m_pwm) begin
        errors++;
        $display("FAIL saw_model cyc%0d: got %h/%b/%b, want %h/%b/%b", i, osc_if.sample,
                 osc_if.sample_valid, osc_if.pwm_out, m_sample, m_valid, m_pwm);
      end
      if (i == 0) begin
        checks++;
        if (osc_if.sample !== 8'h00) begin
          errors++;
          $display("FAIL saw_first: got %h, want 00", osc_if.sample);
        end
      end
      if (osc_if.sample_valid === 1'b1) begin
        checks++;
        if (osc_if.sample !== 8'(prev + 8'd1)) begin
          errors++;
          $display("FAIL saw_step cyc%0d: got %h, want %h", i, osc_if.sample, 8'(prev + 8'd1));
        end
        if (last >= 0) begin
          checks++;
          if (i - last !== 4) begin
            errors++;
            $display("FAIL saw_spacing cyc%0d: got %0d, want 4", i, i - last);
          end
        end
        last = i;
        if (osc_if.sample == 8'h01) begin
          if (first01 < 0) first01 = i;
          else if (second01 < 0) second01 = i;
        end
      end
      prev = osc_if.sample;
    end
    checks++;
    if (second01 - first01 !== 1024 || second01 < 0) begin
      errors++;
      $display("FAIL saw_wrap_period: got %0d, want 1024", second01 - first01);
    end
  endtask

  task automatic test_retune();
    int  last = -1, want;
    bit  found = 0, wrapped = 0, done = 0;
    reset = 1'b1; tick(); reset = 1'b0;
    osc_if.divider = 16'd4; osc_if.wave_sel = 2'b01; osc_if.en = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (osc_if.sample == 8'h10) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL retune_reach_10: sample=%h, want 10 within 200 cycles", osc_if.sample);
    end
    osc_if.divider = 16'd2;
    for (int i = 0; i < 1200 && !done; i++) begin
      tick();
      checks++;
      if (osc_if.sample !== m_sample || osc_if.sample_valid !== m_valid || osc_if.pwm_out !== m_pwm) begin
        errors++;
        $display("FAIL retune_model cyc%0d: got %h/%b/%b, want %h/%b/%b", i, osc_if.sample,
                 osc_if.sample_valid, osc_if.pwm_out, m_sample, m_valid, m_pwm);
      end
      if (osc_if.sample_valid === 1'b1) begin
        want = wrapped ? 2 : 4;
        if (last >= 0) begin
          checks++;
          if (i - last !== want) begin
            errors++;
            $display("FAIL retune_spacing sample=%h: got %0d, want %0d", osc_if.sample, i - last, want);
          end
        end
        last = i;
        if (osc_if.sample == 8'h00) wrapped = 1;
        if (wrapped && osc_if.sample == 8'h08) done = 1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL retune_wrap: wrapped=%0d done=%0d, want both 1", wrapped, done);
    end
  endtask

  task automatic test_silence();
    bit seen = 0;
    osc_if.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (osc_if.sample !== 8'h80 || osc_if.sample_valid !== 1'b0) begin
        errors++;
        $display("FAIL silence_en cyc%0d: got %h/%b, want 80/0", i, osc_if.sample, osc_if.sample_valid);
      end
    end
    osc_if.en = 1'b1;
    tick();
    checks++;
    if (osc_if.sample !== 8'h00) begin
      errors++;
      $display("FAIL silence_restart: got %h, want 00", osc_if.sample);
    end
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (osc_if.sample_valid === 1'b1) begin
        seen = 1;
        checks++;
        if (osc_if.sample !== 8'h01) begin
          errors++;
          $display("FAIL silence_first_step: got %h, want 01", osc_if.sample);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL silence_first_step_timeout: valid=%b, want 1 within 10 cycles", osc_if.sample_valid);
    end
    tick(); tick();
    osc_if.divider = 16'd0;
    tick();
    checks++;
    if (osc_if.sample !== 8'h80 || osc_if.sample_valid !== 1'b0 || osc_if.sample !== m_sample) begin
      errors++;
      $display("FAIL silence_div0: got %h/%b, want 80/0", osc_if.sample, osc_if.sample_valid);
    end
    osc_if.divider = 16'd3;
    tick();
    checks++;
    if (osc_if.sample !== 8'h00 || osc_if.sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL silence_div_restart: got %h/%b, want 00/0", osc_if.sample, osc_if.sample_valid);
    end
  endtask

  task automatic test_tri_square();
    bit  seen = 0, changed = 0;
    int  len = 0;
    logic [7:0] prev;
    reset = 1'b1; tick(); reset = 1'b0;
    osc_if.divider = 16'd1; osc_if.wave_sel = 2'b10; osc_if.en = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (osc_if.sample_valid === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL tri_start: valid=%b, want 1 within 10 cycles", osc_if.sample_valid);
    end
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (osc_if.sample !== shape((k + 1) % 256, 2'b10) || osc_if.sample_valid !== 1'b1) begin
        errors++;
        $display("FAIL tri_seq k=%0d: got %h/%b, want %h/1", k, osc_if.sample,
                 osc_if.sample_valid, shape((k + 1) % 256, 2'b10));
      end
      tick();
    end
    reset = 1'b1; tick(); reset = 1'b0;
    osc_if.wave_sel = 2'b00;
    tick();
    prev = osc_if.sample;
    for (int i = 0; i < 700; i++) begin
      tick();
      checks++;
      if (osc_if.sample !== m_sample || osc_if.sample_valid !== m_valid) begin
        errors++;
        $display("FAIL square_model cyc%0d: got %h/%b, want %h/%b", i, osc_if.sample,
                 osc_if.sample_valid, m_sample, m_valid);
      end
      if (osc_if.sample !== prev) begin
        if (changed) begin
          checks++;
          if (len !== 128) begin
            errors++;
            $display("FAIL square_run value=%h: got %0d cycles, want 128", prev, len);
          end
        end
        changed = 1;
        len = 1;
      end else begin
        len++;
      end
      prev = osc_if.sample;
    end
  endtask

  task automatic test_random();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) osc_if.en = ~osc_if.en;
      if ($urandom_range(0, 149) == 0)
        osc_if.divider = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 3));
      if ($urandom_range(0, 99) == 0) osc_if.wave_sel = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 999) == 0);
      tick();
      checks++;
      if (osc_if.sample !== m_sample || osc_if.sample_valid !== m_valid || osc_if.pwm_out !== m_pwm) begin
        errors++;
        $display("FAIL random_model cyc%0d: got %h/%b/%b, want %h/%b/%b", i, osc_if.sample,
                 osc_if.sample_valid, osc_if.pwm_out, m_sample, m_valid, m_pwm);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_pwm();
    int high = 0;
`ifdef OSC_PWM_EN
    int want_high = 128;
`else
    int want_high = 0;
`endif
    reset = 1'b1; tick(); reset = 1'b0;
    osc_if.wave_sel = 2'b11; osc_if.en = 1'b1; osc_if.divider = 16'd5;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 256; i++) begin
      tick();
      checks++;
      if (osc_if.pwm_out !== m_pwm || osc_if.sample !== 8'h80) begin
        errors++;
        $display("FAIL pwm_model cyc%0d: got pwm=%b sample=%h, want %b/80", i, osc_if.pwm_out,
                 osc_if.sample, m_pwm);
      end
      if (osc_if.pwm_out === 1'b1) high++;
    end
    checks++;
    if (high !== want_high) begin
      errors++;
      $display("FAIL pwm_duty: got %0d high of 256, want %0d", high, want_high);
    end
  endtask

  initial begin
    reset = 1'b1;
    osc_if.en = 1'b1;
    osc_if.divider = 16'd4;
    osc_if.wave_sel = 2'b01;
    test_reset();
    test_sawtooth();
    test_retune();
    test_silence();
    test_tri_square();
    test_random();
    test_pwm();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
